servo_pwm_multi: RTL
====================

Name: servo_pwm_multi

Overview:
- Parametrised multi-channel servo PWM generator; successor to the single-channel push-button servo PWM.
- Uses a shared prescaled period counter and one duty-cycle register per channel.
- Per-channel duty is double-buffered and updated only at a period boundary, so no PWM pulse is ever glitched.
- Adds a direct-load path, a per-channel auto-sweep mode and a duty readback. Inputs come from upstream debouncer/one-shot logic.

Parameters:
- CHANNELS, 4: number of PWM outputs (1..16).
- CNT_W, 20: width of the period counter and duty registers.
- PRESCALE, 5: clk cycles per PWM tick (1 means a tick every clk).
- PERIOD, 200_000: PWM period in ticks.
- MIN_DC, 10_000: minimum duty in ticks (0°).
- MAX_DC, 20_000: maximum duty in ticks (180°).
- CENTER_DC, 15_000: reset duty in ticks (90°).
- STEP, 500: inc/dec/sweep increment in ticks.
- SEL_W, 2: width of ch_sel.
- Legality: MIN_DC <= CENTER_DC <= MAX_DC <= PERIOD, and STEP > 0. Elaboration error otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- ch_sel  in  SEL_W  channel targeted by inc/dec/load/readback.
- inc  in  1  single-cycle pulse: shadow duty += STEP.
- dec  in  1  single-cycle pulse: shadow duty -= STEP.
- load  in  1  single-cycle pulse: shadow duty = load_val.
- load_val  in  CNT_W  value for load.
- sweep_en  in  CHANNELS  per-channel auto-sweep enable.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  one-clk pulse when the period counter wraps to 0.
- dc_rd  out  CNT_W  registered shadow duty of ch_sel.

Behaviour:
- Reset (rst==0 at posedge clk):
  - prescaler=0, period counter cnt=0.
  - pwm_out=0, period_start=0, dc_rd=CENTER_DC.
  - All shadow and active duties = CENTER_DC; all sweep directions = up.
- Reset asserted mid-period restarts the period on the next clk after release. No partial pulse is held.
- Prescaler: counts 0..PRESCALE-1. tick=1 when prescaler==PRESCALE-1.
- cnt advances only on tick and wraps PERIOD-1 -> 0. period_start=1 for the single clk in which that wrap is registered.
- pwm_out[i] <= (cnt < active_dc[i]) every clk. This gives 1 clk latency from cnt; active_dc==0 yields constant low.
- At a wrap (tick with cnt==PERIOD-1), active_dc[i] <= shadow_dc[i] for all i, simultaneously with cnt -> 0.
- Commands act on shadow_dc[ch_sel] in the clk they are sampled. Priority: load > (inc XOR dec). inc and dec both high means no change.
- Commands are ignored when ch_sel >= CHANNELS or sweep_en[ch_sel]==1.
- Arithmetic is computed at CNT_W+1 bits, then clamped:
  - inc: min(shadow+STEP, MAX_DC).
  - dec: max(shadow-STEP, MIN_DC), with no underflow.
  - load: value clamped into [MIN_DC, MAX_DC].
- Sweep: for each i with sweep_en[i]==1, at every wrap the shadow moves STEP in its direction, clamped to the limits.
  - Direction flips when the clamped result equals MAX_DC (up->down) or MIN_DC (down->up).
  - The active copy at that wrap takes the pre-sweep shadow, so active lags shadow by one period.
- Disabling sweep freezes shadow at its current value and retains the direction. Re-enabling resumes from there.
- A command and a wrap in the same clk: the command updates the shadow. active_dc takes the pre-command shadow, so the command becomes visible the following period.
- dc_rd <= shadow_dc[ch_sel], 1 clk latency. Out-of-range ch_sel reads 0.

Test Plan (bench overrides: PRESCALE=2, PERIOD=100, MIN_DC=10, MAX_DC=20, CENTER_DC=15, STEP=4, CHANNELS=4):
- Reset release, no commands -> every pwm_out high for 15 ticks (30 clk) of each 100-tick period; period_start pulses every 200 clk.
- ch_sel=1, inc x2 mid-period -> dc_rd=19 then 20 (second inc clamps to MAX). Channel 1 keeps 15 until the next period_start, then 20. Other channels stay 15.
- ch_sel=2, dec x2 -> shadow 11 then 10 (clamped). Then load_val=3 -> 10 and load_val=50 -> 20. inc+dec together -> 20 unchanged.
- sweep_en=4'b0001 -> ch0 shadow sequence across wraps: 19, 20, 16, 12, 10, 14, ... Active lags one period. inc on ch0 while sweeping is ignored.
- Command on the wrap clk: load_val=12 on ch3 coincident with period_start -> that period still uses 15, next period 12.
- rst low for 1 clk mid-pulse -> all pwm_out 0 next clk, duties back to 15, period restarts at cnt=0.

Source files
------------

// File: rtl/servo_pwm_multi_if.sv
// Command/readback bundle for the multi-channel servo PWM generator.
// The master side issues duty commands; the slave side returns PWM outputs and duty readback.
interface servo_pwm_multi_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 20,
   parameter int SEL_W    = 2
);
   logic [SEL_W-1:0]    ch_sel;
   logic                inc;
   logic                dec;
   logic                load;
   logic [CNT_W-1:0]    load_val;
   logic [CHANNELS-1:0] sweep_en;
   logic [CHANNELS-1:0] pwm_out;
   logic                period_start;
   logic [CNT_W-1:0]    dc_rd;

   modport master (
      output ch_sel, inc, dec, load, load_val, sweep_en,
      input  pwm_out, period_start, dc_rd
   );

   modport slave (
      input  ch_sel, inc, dec, load, load_val, sweep_en,
      output pwm_out, period_start, dc_rd
   );
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared prescaled period counter and per-channel double-buffered duty,
// with inc/dec/load commands, per-channel auto-sweep and registered duty readback.
module servo_pwm_multi #(
   parameter int CHANNELS  = 4,
   parameter int CNT_W     = 20,
   parameter int PRESCALE  = 5,
   parameter int PERIOD    = 200_000,
   parameter int MIN_DC    = 10_000,
   parameter int MAX_DC    = 20_000,
   parameter int CENTER_DC = 15_000,
   parameter int STEP      = 500,
   parameter int SEL_W     = 2
) (
   input logic              clk,
   input logic              rst,
   servo_pwm_multi_if.slave bus
);
   if (!(MIN_DC <= CENTER_DC && CENTER_DC <= MAX_DC && MAX_DC <= PERIOD && STEP > 0 &&
         CHANNELS >= 1 && CHANNELS <= 16 && PRESCALE >= 1 && PERIOD >= 1 &&
         PERIOD <= (2 ** CNT_W))) begin : g_param_check
      $error("servo_pwm_multi: illegal parameter combination");
   end

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   typedef logic [CNT_W:0] wide_t;

   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] CENTER_V = CNT_W'(CENTER_DC);
   localparam logic [CNT_W-1:0] MIN_V    = CNT_W'(MIN_DC);
   localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(MAX_DC);
   localparam wide_t            MIN_X    = wide_t'(MIN_DC);
   localparam wide_t            MAX_X    = wide_t'(MAX_DC);
   localparam wide_t            STEP_X   = wide_t'(STEP);

   logic [PS_W-1:0]     psc;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    shadow_dc [CHANNELS];
   logic [CNT_W-1:0]    active_dc [CHANNELS];
   logic [CHANNELS-1:0] dir_up;
   logic                tick;
   logic                wrap;
   logic                sel_valid;
   logic                sel_sweep;
   logic                cmd_hit;
   logic [CNT_W-1:0]    sel_dc;
   logic [CNT_W-1:0]    cmd_dc;
   logic [CNT_W-1:0]    sweep_dc [CHANNELS];
   logic [CHANNELS-1:0] sweep_flip;

   function automatic logic [CNT_W-1:0] clamp(input wide_t v);
      if (v > MAX_X)
         return MAX_V;
      else if (v < MIN_X)
         return MIN_V;
      else
         return CNT_W'(v);
   endfunction

   function automatic logic [CNT_W-1:0] step_up(input logic [CNT_W-1:0] d);
      return clamp({1'b0, d} + STEP_X);
   endfunction

   // Compare before subtracting so the extended result never wraps below zero.
   function automatic logic [CNT_W-1:0] step_down(input logic [CNT_W-1:0] d);
      if ({1'b0, d} < MIN_X + STEP_X)
         return MIN_V;
      else
         return CNT_W'({1'b0, d} - STEP_X);
   endfunction

   assign tick = (psc == PS_LAST);
   assign wrap = tick && (cnt == CNT_LAST);

   always_comb begin
      sel_valid = 1'b0;
      sel_sweep = 1'b0;
      sel_dc    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (32'(bus.ch_sel) == i) begin
            sel_valid = 1'b1;
            sel_sweep = bus.sweep_en[i];
            sel_dc    = shadow_dc[i];
         end
      end
      cmd_hit = sel_valid && !sel_sweep && (bus.load || (bus.inc ^ bus.dec));
      if (bus.load)
         cmd_dc = clamp({1'b0, bus.load_val});
      else if (bus.inc)
         cmd_dc = step_up(sel_dc);
      else
         cmd_dc = step_down(sel_dc);
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         if (dir_up[i]) begin
            sweep_dc[i]   = step_up(shadow_dc[i]);
            sweep_flip[i] = (step_up(shadow_dc[i]) == MAX_V);
         end else begin
            sweep_dc[i]   = step_down(shadow_dc[i]);
            sweep_flip[i] = (step_down(shadow_dc[i]) == MIN_V);
         end
      end
   end

   // active_dc captures the shadow before any same-clk command or sweep step lands.
   always_ff @(posedge clk) begin
      if (!rst) begin
         psc              <= '0;
         cnt              <= '0;
         dir_up           <= '1;
         bus.pwm_out      <= '0;
         bus.period_start <= 1'b0;
         bus.dc_rd        <= CENTER_V;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_dc[i] <= CENTER_V;
            active_dc[i] <= CENTER_V;
         end
      end else begin
         psc <= tick ? '0 : psc + 1'b1;
         if (tick)
            cnt <= wrap ? '0 : cnt + 1'b1;
         bus.period_start <= wrap;
         bus.dc_rd        <= sel_dc;
         for (int i = 0; i < CHANNELS; i++) begin
            bus.pwm_out[i] <= (cnt < active_dc[i]);
            if (wrap) begin
               active_dc[i] <= shadow_dc[i];
               if (bus.sweep_en[i]) begin
                  shadow_dc[i] <= sweep_dc[i];
                  if (sweep_flip[i])
                     dir_up[i] <= ~dir_up[i];
               end
            end
            if (cmd_hit && 32'(bus.ch_sel) == i)
               shadow_dc[i] <= cmd_dc;
         end
      end
   end
endmodule
